mem_rd_arbiter: RTL and testbench
=================================

Name: mem_rd_arbiter

Overview:
- Shares one AXI-lite-style read port (AR/R channels, 64-bit data) between two requesters:
  - master 0: instruction fetch
  - master 1: load/store unit
- Grants one master at a time.
- Allows one outstanding transaction, held until its R handshake completes.
- Adds a response watchdog that returns SLVERR to the granted master if the slave stalls.

Parameters:
- PRIO_MODE, 2, grant policy: 0 = master 0 fixed priority, 1 = master 1 fixed priority, 2 = round-robin.
- TIMEOUT, 256, cycles allowed in DATA before error return; 0 disables the watchdog.
- CNT_W, 16, watchdog counter width; TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_araddr  in  32  master 0 read address.
- m0_arvalid  in  1  master 0 address valid.
- m0_arready  out  1  master 0 address ready.
- m0_rdata  out  64  master 0 read data.
- m0_rresp  out  2  master 0 response.
- m0_rvalid  out  1  master 0 data valid.
- m0_rready  in  1  master 0 data ready.
- m1_*  (same seven signals, same directions and widths)  master 1.
- s_araddr  out  32  slave read address.
- s_arvalid  out  1  slave address valid.
- s_arready  in  1  slave address ready.
- s_rdata  in  64  slave read data.
- s_rresp  in  2  slave response.
- s_rvalid  in  1  slave data valid.
- s_rready  out  1  slave data ready.
- grant  out  2  one-hot current owner; 00 when idle.
- busy  out  1  high in any state except IDLE.

Behaviour:
- States: IDLE, ADDR, DATA, ERR.
- Registers: state, grant, last (most recent winner), wdog counter, stale flag.
- Reset (rst=0, async):
  - state=IDLE, grant=00, last=1 (round-robin favours master 0 first), wdog=0, stale=0.
  - All outputs 0; s_araddr=0.
- IDLE:
  - If stale=0 and any mX_arvalid: pick winner and register grant; next state ADDR.
  - Arbitration costs 1 cycle; no AR is forwarded in IDLE.
  - PRIO_MODE=2 picks the master not equal to last when both request; a single requester always wins.
- ADDR:
  - s_arvalid = granted arvalid; s_araddr = granted araddr; granted arready = s_arready.
  - Non-granted arready=0.
  - On s_arvalid & s_arready: go to DATA, wdog=0.
  - If the granted arvalid drops before the handshake: go to IDLE, grant=00.
- DATA:
  - Granted rvalid/rdata/rresp = s_rvalid/s_rdata/s_rresp; s_rready = granted rready.
  - Non-granted rvalid=0, rdata=0, rresp=0.
  - On s_rvalid & s_rready: go to IDLE, last=winner, grant=00.
  - Otherwise wdog increments each cycle.
  - If TIMEOUT≠0 and wdog==TIMEOUT-1 with no handshake that cycle: go to ERR, stale=1.
- ERR:
  - Granted rvalid=1, rdata=0, rresp=2'b10; s_rready=1.
  - On granted rready: go to IDLE, last=winner, grant=00.
- Stale drain:
  - While stale=1 and not in DATA, s_rready=1.
  - A late s_rvalid is consumed and discarded, and clears stale.
  - New grants are blocked while stale=1.
- Handshake rules:
  - A request arriving during an active transaction waits; its arvalid must stay high.
  - Simultaneous requests in IDLE are resolved by PRIO_MODE only.
  - The loser sees arready=0 until granted.
- Back-to-back: minimum 3 cycles per transaction (IDLE→ADDR→DATA). The next grant is decided in the IDLE cycle after the R handshake.
- Reset mid-transaction: everything returns to the reset state immediately; the in-flight slave response is not tracked.
- All master-facing and slave-facing outputs are combinational muxes of state/grant plus the selected inputs. There is no combinational path from one master's inputs to the other master's outputs.

Test Plan:
- Only m0 requests araddr=0x80000000; slave arready=1, returns rdata=0x00000013_00000093 one cycle later → m0 gets that rdata, rresp=00; grant=01 in ADDR/DATA; busy for 2 cycles; grant=00 after.
- m0 and m1 assert arvalid in the same cycle, PRIO_MODE=2, five consecutive rounds → grants alternate m0,m1,m0,m1,m0; loser's arready stays 0 while waiting.
- PRIO_MODE=1, both requesting continuously → m1 wins every round; m0 is never granted.
- TIMEOUT=4, slave never raises rvalid → ERR after 4 DATA cycles; master sees rvalid=1, rresp=10, rdata=0; a late slave rvalid is drained with s_rready=1 before the next grant.
- Granted master holds rready=0 for 3 cycles while s_rvalid=1 → s_rready=0 during the stall; completion on the first rready=1 cycle; rdata stable throughout.
- rst pulled low in DATA → all outputs 0 asynchronously; after release, a new m1 request is granted normally.

Source files
------------

// File: rtl/mem_rd_arbiter.sv
// Two-master read arbiter in front of a single AXI-lite-style AR/R slave port.
// One transaction in flight; a watchdog returns SLVERR if the slave never answers.
module mem_rd_arbiter #(
    parameter int PRIO_MODE = 2,
    parameter int TIMEOUT   = 256,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [63:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,

    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [63:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,

    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [63:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,

    output logic [1:0]  grant,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    localparam int unsigned        TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TO_LAST_I);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             stale_q, stale_d;

    logic win, g_arvalid, g_rready, pick1;

    assign win       = grant_q[1];
    assign g_arvalid = (grant_q[0] & m0_arvalid) | (grant_q[1] & m1_arvalid);
    assign g_rready  = (grant_q[0] & m0_rready)  | (grant_q[1] & m1_rready);
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);

    // A lone requester always wins; contention is settled by the policy.
    always_comb begin
        pick1 = m1_arvalid;
        if (m0_arvalid && m1_arvalid) begin
            if (PRIO_MODE == 0)      pick1 = 1'b0;
            else if (PRIO_MODE == 1) pick1 = 1'b1;
            else                     pick1 = ~last_q;
        end
    end

    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        case (state_q)
            ADDR: begin
                s_arvalid  = g_arvalid;
                s_araddr   = grant_q[1] ? m1_araddr : m0_araddr;
                m0_arready = grant_q[0] & s_arready;
                m1_arready = grant_q[1] & s_arready;
            end
            DATA: begin
                s_rready  = g_rready;
                m0_rvalid = grant_q[0] & s_rvalid;
                m0_rdata  = grant_q[0] ? s_rdata : '0;
                m0_rresp  = grant_q[0] ? s_rresp : '0;
                m1_rvalid = grant_q[1] & s_rvalid;
                m1_rdata  = grant_q[1] ? s_rdata : '0;
                m1_rresp  = grant_q[1] ? s_rresp : '0;
            end
            ERR: begin
                s_rready  = 1'b1;
                m0_rvalid = grant_q[0];
                m0_rresp  = grant_q[0] ? 2'b10 : 2'b00;
                m1_rvalid = grant_q[1];
                m1_rresp  = grant_q[1] ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
        // Swallow a late response from a timed-out transaction.
        if (stale_q && state_q != DATA) s_rready = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        stale_d = stale_q;
        if (stale_q && state_q != DATA && s_rvalid) stale_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stale_q && (m0_arvalid || m1_arvalid)) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (g_arvalid && s_arready) begin
                    state_d = DATA;
                    wdog_d  = '0;
                end else if (!g_arvalid) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end
            end
            DATA: begin
                if (s_rvalid && g_rready) begin
                    state_d = IDLE;
                    last_d  = win;
                    grant_d = 2'b00;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                    if (TIMEOUT != 0 && wdog_q == TO_LAST) begin
                        state_d = ERR;
                        stale_d = 1'b1;
                    end
                end
            end
            ERR: begin
                if (g_rready) begin
                    state_d = IDLE;
                    last_d  = win;
                    grant_d = 2'b00;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            stale_q <= stale_d;
        end
    end
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Bench for mem_rd_arbiter: a round-robin/short-watchdog instance and a
// master-1-priority instance share stimulus; R beats are scored from a queue.
module tb_mem_rd_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m0_araddr, m1_araddr;
    logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
    logic        m0_arready, m1_arready, m0_rvalid, m1_rvalid;
    logic [63:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_rdata;
    logic [1:0]  s_rresp;
    logic [1:0]  grant;
    logic        busy;

    logic        p1_m0_arready, p1_m1_arready, p1_m0_rvalid, p1_m1_rvalid;
    logic [63:0] p1_m0_rdata, p1_m1_rdata;
    logic [1:0]  p1_m0_rresp, p1_m1_rresp;
    logic [31:0] p1_s_araddr;
    logic        p1_s_arvalid, p1_s_rready, p1_busy;
    logic [1:0]  p1_grant;

    mem_rd_arbiter #(.PRIO_MODE(2), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    mem_rd_arbiter #(.PRIO_MODE(1), .TIMEOUT(4), .CNT_W(8)) dut_p1 (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(p1_m0_arready),
        .m0_rdata(p1_m0_rdata), .m0_rresp(p1_m0_rresp), .m0_rvalid(p1_m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(p1_m1_arready),
        .m1_rdata(p1_m1_rdata), .m1_rresp(p1_m1_rresp), .m1_rvalid(p1_m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(p1_s_araddr), .s_arvalid(p1_s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(p1_s_rready),
        .grant(p1_grant), .busy(p1_busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        mst;
        logic [63:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];

    typedef struct packed {
        logic       r0;
        logic       r1;
        logic [1:0] g_rr;
        logic [1:0] g_p1;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [63:0] rd_of(input logic [31:0] a);
        return {a ^ 32'h8000_0013, a ^ 32'h8000_0093};
    endfunction
    function automatic logic [1:0] rs_of(input logic [31:0] a);
        return {1'b0, a[4]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input logic mst, input logic [63:0] d, input logic [1:0] r);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_r: m%0d got data %h, want no response", mst, d);
        end else begin
            e = exp_q.pop_front();
            chk("r_master", 64'(mst), 64'(e.mst));
            chk("r_data", d, e.data);
            chk("r_resp", 64'(r), 64'(e.resp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    // Slave: answers one cycle after AR unless muted; late_rv injects a stray beat.
    logic        rsp_pend = 1'b0;
    logic [63:0] rsp_data = '0;
    logic [1:0]  rsp_resp = '0;
    logic        late_rv  = 1'b0;
    int          slv_mode = 0;
    assign s_rvalid = rsp_pend | late_rv;
    assign s_rdata  = rsp_pend ? rsp_data : 64'hBAD0_BAD0_BAD0_BAD0;
    assign s_rresp  = rsp_pend ? rsp_resp : 2'b00;

    always @(posedge clk) begin : slave
        logic ar_hs, r_hs;
        logic [31:0] a;
        ar_hs = s_arvalid & s_arready;
        r_hs  = s_rvalid & s_rready;
        a     = s_araddr;
        #1;
        if (!rst) rsp_pend = 1'b0;
        else begin
            if (r_hs) rsp_pend = 1'b0;
            if (ar_hs && slv_mode == 0) begin
                rsp_pend = 1'b1;
                rsp_data = rd_of(a);
                rsp_resp = rs_of(a);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (m0_rvalid && m0_rready) pop_chk(1'b0, m0_rdata, m0_rresp);
            if (m1_rvalid && m1_rready) pop_chk(1'b1, m1_rdata, m1_rresp);
        end
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic        w;
        logic [31:0] a;

        tbl[0] = {1'b0, 1'b1, 2'b10, 2'b10};
        tbl[1] = {1'b1, 1'b1, 2'b01, 2'b10};
        tbl[2] = {1'b1, 1'b1, 2'b10, 2'b10};
        tbl[3] = {1'b1, 1'b1, 2'b01, 2'b10};
        tbl[4] = {1'b1, 1'b1, 2'b10, 2'b10};
        tbl[5] = {1'b1, 1'b1, 2'b01, 2'b10};
        tbl[6] = {1'b0, 1'b1, 2'b10, 2'b10};
        tbl[7] = {1'b1, 1'b1, 2'b01, 2'b10};
        tbl[8] = {1'b1, 1'b0, 2'b01, 2'b01};
        tbl[9] = {1'b1, 1'b1, 2'b10, 2'b10};

        m0_araddr = 32'h1234_5678; m0_arvalid = 1'b1; m0_rready = 1'b1;
        m1_araddr = 32'h8765_4321; m1_arvalid = 1'b1; m1_rready = 1'b1;
        s_arready = 1'b1;

        // Reset state, with requests pending to show nothing leaks through.
        #12;
        chk("rst_grant", 64'(grant), 64'(2'b00));
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_s_arvalid", 64'(s_arvalid), 64'(1'b0));
        chk("rst_s_araddr", 64'(s_araddr), 64'(32'h0));
        chk("rst_s_rready", 64'(s_rready), 64'(1'b0));
        chk("rst_arready", 64'({m0_arready, m1_arready}), 64'(2'b00));
        chk("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(2'b00));
        chk("rst_p1_outs", 64'(|{p1_m0_arready, p1_m1_arready, p1_m0_rvalid, p1_m1_rvalid,
            p1_m0_rdata, p1_m1_rdata, p1_m0_rresp, p1_m1_rresp, p1_s_araddr,
            p1_s_arvalid, p1_s_rready, p1_busy, p1_grant}), 64'(1'b0));
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        #10 rst = 1'b1;
        tick();

        // Single m0 read.
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1;
        exp_q.push_back('{1'b0, 64'h0000_0013_0000_0093, 2'b00});
        neg();
        chk("t1_idle_busy", 64'(busy), 64'(1'b0));
        chk("t1_idle_no_ar", 64'(s_arvalid), 64'(1'b0));
        tick();
        neg();
        chk("t1_addr_grant", 64'(grant), 64'(2'b01));
        chk("t1_addr_busy", 64'(busy), 64'(1'b1));
        chk("t1_s_arvalid", 64'(s_arvalid), 64'(1'b1));
        chk("t1_s_araddr", 64'(s_araddr), 64'(32'h8000_0000));
        chk("t1_arready", 64'({m1_arready, m0_arready}), 64'(2'b01));
        tick();
        m0_arvalid = 1'b0;
        neg();
        chk("t1_data_grant", 64'(grant), 64'(2'b01));
        chk("t1_data_busy", 64'(busy), 64'(1'b1));
        chk("t1_s_rready", 64'(s_rready), 64'(1'b1));
        tick();
        neg();
        chk("t1_done_grant", 64'(grant), 64'(2'b00));
        chk("t1_done_busy", 64'(busy), 64'(1'b0));
        chk("t1_q_empty", 64'(exp_q.size()), 64'(0));

        // Arbitration table; restart so round-robin begins favouring m0.
        rst = 1'b0;
        #2 rst = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            m0_araddr = 32'h8000_0000 + 32'(i * 16);
            m1_araddr = 32'h4000_0000 + 32'(i * 16);
            m0_arvalid = tbl[i].r0;
            m1_arvalid = tbl[i].r1;
            w = tbl[i].g_rr[1];
            a = w ? m1_araddr : m0_araddr;
            exp_q.push_back('{w, rd_of(a), rs_of(a)});
            tick();
            neg();
            chk($sformatf("tbl%0d_grant_rr", i), 64'(grant), 64'(tbl[i].g_rr));
            chk($sformatf("tbl%0d_grant_p1", i), 64'(p1_grant), 64'(tbl[i].g_p1));
            chk($sformatf("tbl%0d_win_arready", i), 64'(w ? m1_arready : m0_arready), 64'(1'b1));
            if (tbl[i].r0 && tbl[i].r1)
                chk($sformatf("tbl%0d_lose_arready", i), 64'(w ? m0_arready : m1_arready), 64'(1'b0));
            tick();
            if (w) m1_arvalid = 1'b0;
            else   m0_arvalid = 1'b0;
            neg();
            chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(1'b1));
            tick();
            chk($sformatf("tbl%0d_q_empty", i), 64'(exp_q.size()), 64'(0));
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;

        // Master stalls rready for 3 cycles while data waits.
        m0_araddr = 32'h8000_0110; m0_arvalid = 1'b1;
        exp_q.push_back('{1'b0, rd_of(32'h8000_0110), rs_of(32'h8000_0110)});
        tick();
        tick();
        m0_arvalid = 1'b0;
        m0_rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neg();
            chk("stall_s_rready", 64'(s_rready), 64'(1'b0));
            chk("stall_rvalid", 64'(m0_rvalid), 64'(1'b1));
            chk("stall_rdata", m0_rdata, rd_of(32'h8000_0110));
            tick();
        end
        m0_rready = 1'b1;
        neg();
        chk("stall_release_s_rready", 64'(s_rready), 64'(1'b1));
        tick();
        neg();
        chk("stall_done_busy", 64'(busy), 64'(1'b0));
        chk("stall_done_rvalid", 64'(m0_rvalid), 64'(1'b0));
        chk("stall_q_empty", 64'(exp_q.size()), 64'(0));

        // Watchdog: slave goes silent, then a late beat is drained.
        slv_mode = 1;
        m1_araddr = 32'h4000_0200; m1_arvalid = 1'b1;
        exp_q.push_back('{1'b1, 64'h0, 2'b10});
        tick();
        tick();
        m1_arvalid = 1'b0;
        m1_rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            neg();
            chk("to_data_rvalid", 64'(m1_rvalid), 64'(1'b0));
            chk("to_data_grant", 64'(grant), 64'(2'b10));
            tick();
        end
        neg();
        chk("err_rvalid", 64'(m1_rvalid), 64'(1'b1));
        chk("err_rresp", 64'(m1_rresp), 64'(2'b10));
        chk("err_rdata", m1_rdata, 64'h0);
        chk("err_s_rready", 64'(s_rready), 64'(1'b1));
        chk("err_m0_rvalid", 64'(m0_rvalid), 64'(1'b0));
        tick();
        m1_rready = 1'b1;
        neg();
        tick();
        m0_araddr = 32'h8000_0300; m0_arvalid = 1'b1;
        neg();
        chk("stale_s_rready", 64'(s_rready), 64'(1'b1));
        chk("stale_busy", 64'(busy), 64'(1'b0));
        tick();
        late_rv = 1'b1;
        neg();
        chk("stale_blocked_grant", 64'(grant), 64'(2'b00));
        chk("stale_drain_rready", 64'(s_rready), 64'(1'b1));
        chk("stale_m0_rvalid", 64'(m0_rvalid), 64'(1'b0));
        tick();
        late_rv = 1'b0;
        slv_mode = 0;
        exp_q.push_back('{1'b0, rd_of(32'h8000_0300), rs_of(32'h8000_0300)});
        neg();
        chk("stale_clear_grant", 64'(grant), 64'(2'b00));
        tick();
        neg();
        chk("post_stale_grant", 64'(grant), 64'(2'b01));
        tick();
        m0_arvalid = 1'b0;
        neg();
        tick();
        chk("post_stale_q_empty", 64'(exp_q.size()), 64'(0));

        // Requester withdraws while slave holds off arready.
        s_arready = 1'b0;
        m1_araddr = 32'h4000_0410; m1_arvalid = 1'b1;
        tick();
        neg();
        chk("abort_arready", 64'(m1_arready), 64'(1'b0));
        chk("abort_s_arvalid", 64'(s_arvalid), 64'(1'b1));
        tick();
        m1_arvalid = 1'b0;
        neg();
        chk("abort_drop_s_arvalid", 64'(s_arvalid), 64'(1'b0));
        tick();
        neg();
        chk("abort_grant", 64'(grant), 64'(2'b00));
        chk("abort_busy", 64'(busy), 64'(1'b0));
        s_arready = 1'b1;

        // Asynchronous reset while in DATA.
        slv_mode = 1;
        m1_araddr = 32'h4000_0400; m1_arvalid = 1'b1;
        tick();
        tick();
        m1_arvalid = 1'b0;
        neg();
        chk("mid_data_busy", 64'(busy), 64'(1'b1));
        #1 rst = 1'b0;
        #1;
        chk("arst_grant", 64'(grant), 64'(2'b00));
        chk("arst_busy", 64'(busy), 64'(1'b0));
        chk("arst_s_rready", 64'(s_rready), 64'(1'b0));
        chk("arst_m_outs", 64'(|{m0_arready, m1_arready, m0_rvalid, m1_rvalid,
            m0_rdata, m1_rdata, m0_rresp, m1_rresp, s_arvalid, s_araddr}), 64'(1'b0));
        chk("arst_p1_outs", 64'(|{p1_m0_arready, p1_m1_arready, p1_m0_rvalid, p1_m1_rvalid,
            p1_m0_rdata, p1_m1_rdata, p1_m0_rresp, p1_m1_rresp, p1_s_araddr,
            p1_s_arvalid, p1_s_rready, p1_busy, p1_grant}), 64'(1'b0));
        #1 rst = 1'b1;
        slv_mode = 0;
        tick();
        m1_araddr = 32'h4000_0510; m1_arvalid = 1'b1;
        exp_q.push_back('{1'b1, rd_of(32'h4000_0510), rs_of(32'h4000_0510)});
        tick();
        neg();
        chk("after_rst_grant", 64'(grant), 64'(2'b10));
        tick();
        m1_arvalid = 1'b0;
        neg();
        tick();
        chk("final_q_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
